// File: rtl/lvds_word_align_pkg.sv
// Shared definitions for the LVDS word aligner: lane state encoding and
// a constant clog2 used to size the per-lane counters.
package lvds_word_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } lane_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/lvds_word_align_lane.sv
// Single-lane alignment engine: searches for the training word with bitslip
// pulses, declares lock after consecutive matches, and monitors lock loss.
module lvds_word_align_lane
  import lvds_word_align_pkg::*;
#(
  parameter int DATA_WIDTH    = 10,
  parameter int SETTLE_CYCLES = 4,
  parameter int MATCH_COUNT   = 3,
  parameter int MAX_SLIPS     = 10,
  parameter int LOSS_COUNT    = 8,
  localparam int SW = clog2(MAX_SLIPS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  align_en,
  input  logic                  auto_realign,
  input  logic [DATA_WIDTH-1:0] pattern,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  bitslip,
  output logic                  ch_locked,
  output logic                  ch_fail,
  output logic                  lock_lost,
  output logic [SW-1:0]         slip_cnt
);

  localparam int MW = clog2(MATCH_COUNT + 1);
  localparam int EW = clog2(LOSS_COUNT + 1);
  localparam int TW = clog2(SETTLE_CYCLES + 1);

  localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_COUNT - 1);
  localparam logic [EW-1:0] LOSS_LAST   = EW'(LOSS_COUNT - 1);
  localparam logic [EW-1:0] LOSS_MAX    = EW'(LOSS_COUNT);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] SLIP_MAX    = SW'(MAX_SLIPS);

  lane_state_e   state, state_n;
  logic [MW-1:0] match_cnt, match_n;
  logic [EW-1:0] err_cnt, err_n;
  logic [TW-1:0] settle_cnt, settle_n;
  logic [SW-1:0] slip_n;
  logic          bitslip_n, locked_n, fail_n, lost_n;
  logic          hit;

  assign hit = (data == pattern);

  always_comb begin
    state_n   = state;
    match_n   = match_cnt;
    err_n     = err_cnt;
    settle_n  = settle_cnt;
    slip_n    = slip_cnt;
    bitslip_n = 1'b0;
    locked_n  = ch_locked;
    fail_n    = ch_fail;
    lost_n    = lock_lost;
    if (!align_en) begin
      state_n  = ST_IDLE;
      match_n  = '0;
      err_n    = '0;
      settle_n = '0;
      slip_n   = '0;
      locked_n = 1'b0;
      fail_n   = 1'b0;
      lost_n   = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n  = ST_CHECK;
          match_n  = '0;
          err_n    = '0;
          settle_n = '0;
          slip_n   = '0;
          locked_n = 1'b0;
          fail_n   = 1'b0;
          lost_n   = 1'b0;
        end
        ST_CHECK: begin
          if (hit) begin
            match_n = match_cnt + 1'b1;
            if (match_cnt == MATCH_LAST) begin
              state_n  = ST_LOCKED;
              locked_n = 1'b1;
              err_n    = '0;
            end
          end else if (slip_cnt < SLIP_MAX) begin
            match_n   = '0;
            slip_n    = slip_cnt + 1'b1;
            bitslip_n = 1'b1;
            settle_n  = '0;
            state_n   = ST_SETTLE;
          end else begin
            state_n = ST_FAIL;
            fail_n  = 1'b1;
          end
        end
        // Deserialiser output is unreliable right after a slip; data ignored.
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state_n = ST_CHECK;
          else                           settle_n = settle_cnt + 1'b1;
        end
        ST_LOCKED: begin
          if (hit) begin
            err_n = '0;
          end else begin
            if (err_cnt != LOSS_MAX) err_n = err_cnt + 1'b1;
            if (err_cnt >= LOSS_LAST) begin
              lost_n = 1'b1;
              if (auto_realign) begin
                locked_n = 1'b0;
                slip_n   = '0;
                match_n  = '0;
                err_n    = '0;
                state_n  = ST_CHECK;
              end
            end
          end
        end
        ST_FAIL: ;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      match_cnt  <= '0;
      err_cnt    <= '0;
      settle_cnt <= '0;
      slip_cnt   <= '0;
      bitslip    <= 1'b0;
      ch_locked  <= 1'b0;
      ch_fail    <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      state      <= state_n;
      match_cnt  <= match_n;
      err_cnt    <= err_n;
      settle_cnt <= settle_n;
      slip_cnt   <= slip_n;
      bitslip    <= bitslip_n;
      ch_locked  <= locked_n;
      ch_fail    <= fail_n;
      lock_lost  <= lost_n;
    end
  end

endmodule

// File: rtl/lvds_word_align.sv
// Multi-lane LVDS word aligner: one independent engine per lane plus
// registered all-locked / any-failed summary flags.
module lvds_word_align
  import lvds_word_align_pkg::*;
#(
  parameter int DATA_WIDTH    = 10,
  parameter int NUM_CH        = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int MATCH_COUNT   = 3,
  parameter int MAX_SLIPS     = 10,
  parameter int LOSS_COUNT    = 8,
  localparam int SW = clog2(MAX_SLIPS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         align_en,
  input  logic                         auto_realign,
  input  logic [DATA_WIDTH-1:0]        pattern,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  output logic [NUM_CH-1:0]            bitslip,
  output logic [NUM_CH-1:0]            ch_locked,
  output logic [NUM_CH-1:0]            ch_fail,
  output logic [NUM_CH-1:0]            lock_lost,
  output logic [NUM_CH*SW-1:0]         slip_cnt,
  output logic                         align_done,
  output logic                         align_fail
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    lvds_word_align_lane #(
      .DATA_WIDTH   (DATA_WIDTH),
      .SETTLE_CYCLES(SETTLE_CYCLES),
      .MATCH_COUNT  (MATCH_COUNT),
      .MAX_SLIPS    (MAX_SLIPS),
      .LOSS_COUNT   (LOSS_COUNT)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .align_en    (align_en),
      .auto_realign(auto_realign),
      .pattern     (pattern),
      .data        (data_in[g*DATA_WIDTH +: DATA_WIDTH]),
      .bitslip     (bitslip[g]),
      .ch_locked   (ch_locked[g]),
      .ch_fail     (ch_fail[g]),
      .lock_lost   (lock_lost[g]),
      .slip_cnt    (slip_cnt[g*SW +: SW])
    );
  end

  // Gated by align_en so a disable clears the summary on the same edge as the lanes.
  always_ff @(posedge clk) begin
    if (rst || !align_en) begin
      align_done <= 1'b0;
      align_fail <= 1'b0;
    end else begin
      align_done <= &ch_locked;
      align_fail <= |ch_fail;
    end
  end

endmodule

// File: tb/tb_lvds_word_align.sv
// Randomized bench for lvds_word_align: rotating-lane channel model plus a
// cycle-level behavioural reference of the alignment rules.
module tb_lvds_word_align;
  import lvds_word_align_pkg::*;

  localparam int DW  = 10;
  localparam int NCH = 2;
  localparam int SET = 4;
  localparam int MC  = 3;
  localparam int MS  = 10;
  localparam int LC  = 8;
  localparam int SW  = clog2(MS + 1);
  localparam logic [DW-1:0] PAT = 10'h3F0;

  logic              clk = 1'b0;
  logic              rst, align_en, auto_realign;
  logic [DW-1:0]     pattern;
  logic [NCH*DW-1:0] data_in;
  logic [NCH-1:0]    bitslip, ch_locked, ch_fail, lock_lost;
  logic [NCH*SW-1:0] slip_cnt;
  logic              align_done, align_fail;

  lvds_word_align #(
    .DATA_WIDTH(DW), .NUM_CH(NCH), .SETTLE_CYCLES(SET),
    .MATCH_COUNT(MC), .MAX_SLIPS(MS), .LOSS_COUNT(LC)
  ) dut (
    .clk(clk), .rst(rst), .align_en(align_en), .auto_realign(auto_realign),
    .pattern(pattern), .data_in(data_in), .bitslip(bitslip),
    .ch_locked(ch_locked), .ch_fail(ch_fail), .lock_lost(lock_lost),
    .slip_cnt(slip_cnt), .align_done(align_done), .align_fail(align_fail)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // channel model: lane word rotates left once per slip, a few cycles after the pulse
  int            rot [NCH];
  int            cd  [NCH];
  logic [DW-1:0] base [NCH];
  bit            ovr [NCH];
  logic [DW-1:0] ovr_val [NCH];
  int            pulses [NCH];
  int            pq [NCH][$];
  int            cyc = 0;

  // reference model state
  bit     m_act [NCH];
  int     m_settle [NCH], m_match [NCH], m_slip [NCH], m_err [NCH];
  logic [NCH-1:0] m_lock, m_fail, m_lost, m_pulse;
  logic   m_done, m_afail;

  function automatic logic [DW-1:0] rotl(input logic [DW-1:0] w, input int r);
    logic [DW-1:0] x;
    x = w;
    for (int k = 0; k < (r % DW); k++) x = {x[DW-2:0], x[DW-1]};
    return x;
  endfunction

  function automatic logic [DW-1:0] junk();
    logic [DW-1:0] v;
    do v = DW'($urandom_range(0, (1 << DW) - 1)); while (v == PAT);
    return v;
  endfunction

  task automatic model_step();
    logic [DW-1:0] w;
    if (rst || !align_en) begin
      m_done = 1'b0; m_afail = 1'b0;
      m_lock = '0; m_fail = '0; m_lost = '0; m_pulse = '0;
      for (int i = 0; i < NCH; i++) begin
        m_act[i] = 1'b0; m_settle[i] = 0; m_match[i] = 0; m_slip[i] = 0; m_err[i] = 0;
      end
    end else begin
      m_done  = &m_lock;
      m_afail = |m_fail;
      for (int i = 0; i < NCH; i++) begin
        w = data_in[i*DW +: DW];
        m_pulse[i] = 1'b0;
        if (!m_act[i]) begin
          m_act[i] = 1'b1; m_match[i] = 0; m_slip[i] = 0; m_err[i] = 0; m_settle[i] = 0;
          m_lock[i] = 1'b0; m_fail[i] = 1'b0; m_lost[i] = 1'b0;
        end else if (m_fail[i]) begin
          m_fail[i] = 1'b1;
        end else if (m_settle[i] > 0) begin
          m_settle[i]--;
        end else if (m_lock[i]) begin
          if (w == PAT) m_err[i] = 0;
          else begin
            m_err[i] = (m_err[i] + 1 > LC) ? LC : m_err[i] + 1;
            if (m_err[i] == LC) begin
              m_lost[i] = 1'b1;
              if (auto_realign) begin
                m_lock[i] = 1'b0; m_slip[i] = 0; m_match[i] = 0; m_err[i] = 0;
              end
            end
          end
        end else if (w == PAT) begin
          m_match[i]++;
          if (m_match[i] == MC) begin m_lock[i] = 1'b1; m_err[i] = 0; end
        end else if (m_slip[i] < MS) begin
          m_match[i] = 0; m_slip[i]++; m_pulse[i] = 1'b1; m_settle[i] = SET;
        end else begin
          m_fail[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    for (int i = 0; i < NCH; i++)
      data_in[i*DW +: DW] = ovr[i] ? ovr_val[i] : rotl(base[i], rot[i]);
    @(posedge clk);
    model_step();
    for (int i = 0; i < NCH; i++)
      if (cd[i] > 0) begin
        cd[i]--;
        if (cd[i] == 0) rot[i]++;
      end
    #1;
    cyc++;
    chk("bitslip", 32'(bitslip), 32'(m_pulse));
    chk("ch_locked", 32'(ch_locked), 32'(m_lock));
    chk("ch_fail", 32'(ch_fail), 32'(m_fail));
    chk("lock_lost", 32'(lock_lost), 32'(m_lost));
    chk("align_done", 32'(align_done), 32'(m_done));
    chk("align_fail", 32'(align_fail), 32'(m_afail));
    for (int i = 0; i < NCH; i++) begin
      chk("slip_cnt", 32'(slip_cnt[i*SW +: SW]), 32'(m_slip[i]));
      if (bitslip[i]) begin
        pulses[i]++;
        cd[i] = SET - 1;
        pq[i].push_back(cyc);
      end
    end
  endtask

  task automatic restart();
    align_en = 1'b0;
    tick();
    for (int i = 0; i < NCH; i++) begin
      rot[i] = 0; cd[i] = 0; pulses[i] = 0; pq[i].delete();
      ovr[i] = 1'b0; base[i] = PAT;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; align_en = 1'b0; auto_realign = 1'b1; pattern = PAT; data_in = '0;
    for (int i = 0; i < NCH; i++) begin
      rot[i] = 0; cd[i] = 0; base[i] = PAT; ovr[i] = 1'b0; ovr_val[i] = '0; pulses[i] = 0;
      m_act[i] = 1'b0; m_settle[i] = 0; m_match[i] = 0; m_slip[i] = 0; m_err[i] = 0;
    end
    m_lock = '0; m_fail = '0; m_lost = '0; m_pulse = '0; m_done = 1'b0; m_afail = 1'b0;

    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_outs", {bitslip, ch_locked, ch_fail, lock_lost, slip_cnt, align_done, align_fail}, '0);

    // lane0 aligned, lane1 three slips away
    restart();
    base[1] = rotl(PAT, DW - 3);
    align_en = 1'b1;
    repeat (40) tick();
    chk("s1_pulses0", pulses[0], 0);
    chk("s1_pulses1", pulses[1], 3);
    if (pq[1].size() == 3) begin
      chk("s1_gap_a", pq[1][1] - pq[1][0], SET + 1);
      chk("s1_gap_b", pq[1][2] - pq[1][1], SET + 1);
    end
    chk("s1_slip1", 32'(slip_cnt[SW +: SW]), 3);
    chk("s1_locked", 32'(ch_locked), 3);
    chk("s1_done", 32'(align_done), 1);

    // lane1 dead: exhaust the slip budget
    restart();
    ovr[1] = 1'b1; ovr_val[1] = '0;
    align_en = 1'b1;
    repeat (90) tick();
    chk("s2_pulses1", pulses[1], MS);
    chk("s2_fail1", 32'(ch_fail[1]), 1);
    chk("s2_afail", 32'(align_fail), 1);
    chk("s2_slip1", 32'(slip_cnt[SW +: SW]), MS);
    chk("s2_locked0", 32'(ch_locked[0]), 1);

    // lock monitor with auto_realign
    restart();
    auto_realign = 1'b1;
    align_en = 1'b1;
    repeat (10) tick();
    ovr[0] = 1'b1;
    repeat (LC - 1) begin ovr_val[0] = junk(); tick(); end
    ovr[0] = 1'b0;
    tick();
    chk("s3_nolost", 32'(lock_lost[0]), 0);
    chk("s3_stilllk", 32'(ch_locked[0]), 1);
    ovr[0] = 1'b1;
    repeat (LC) begin ovr_val[0] = junk(); tick(); end
    chk("s3_lost", 32'(lock_lost[0]), 1);
    chk("s3_unlocked", 32'(ch_locked[0]), 0);
    ovr[0] = 1'b0;
    base[0] = rotl(PAT, DW - 1);
    pulses[0] = 0;
    repeat (30) tick();
    chk("s3_reslip", pulses[0], 1);
    chk("s3_relock", 32'(ch_locked[0]), 1);
    chk("s3_sticky", 32'(lock_lost[0]), 1);

    // lock monitor without auto_realign
    restart();
    auto_realign = 1'b0;
    align_en = 1'b1;
    repeat (10) tick();
    ovr[0] = 1'b1;
    repeat (LC) begin ovr_val[0] = junk(); tick(); end
    ovr[0] = 1'b0;
    tick();
    chk("s4_lost", 32'(lock_lost[0]), 1);
    chk("s4_locked", 32'(ch_locked[0]), 1);
    chk("s4_nopulse", pulses[0], 0);
    repeat (4) tick();

    // disable mid-SETTLE, then reset mid-search
    restart();
    auto_realign = 1'b1;
    base[1] = rotl(PAT, 5);
    align_en = 1'b1;
    n = 0;
    while (!bitslip[1] && n < 20) begin tick(); n++; end
    chk("s5_pulse_seen", 32'(bitslip[1]), 1);
    tick();
    align_en = 1'b0;
    tick();
    chk("s5_dis_outs", {bitslip, ch_locked, ch_fail, lock_lost, slip_cnt, align_done, align_fail}, '0);
    align_en = 1'b1;
    tick();
    chk("s5_restart", 32'(slip_cnt), 0);
    repeat (8) tick();
    rst = 1'b1;
    tick();
    chk("s5_rst_outs", {bitslip, ch_locked, ch_fail, lock_lost, slip_cnt, align_done, align_fail}, '0);
    rst = 1'b0;
    tick();
    chk("s5_rst_restart", 32'(slip_cnt), 0);
    repeat (50) tick();

    // match, mismatch, match, match must not lock
    restart();
    ovr[0] = 1'b1; ovr_val[0] = PAT;
    ovr[1] = 1'b1; ovr_val[1] = PAT;
    align_en = 1'b1;
    tick();
    tick();
    ovr_val[0] = junk();
    tick();
    ovr_val[0] = PAT;
    repeat (SET) tick();
    tick();
    tick();
    chk("s6_nolock", 32'(ch_locked[0]), 0);
    tick();
    chk("s6_lock", 32'(ch_locked[0]), 1);

    // randomized offsets and corruption bursts
    for (int it = 0; it < 6; it++) begin
      int burst, blane;
      restart();
      for (int i = 0; i < NCH; i++) base[i] = rotl(PAT, $urandom_range(0, DW - 1));
      auto_realign = 1'($urandom_range(0, 1));
      align_en = 1'b1;
      burst = 0; blane = 0;
      repeat (120) begin
        if (burst == 0 && $urandom_range(0, 7) == 0) begin
          burst = $urandom_range(1, LC + 2);
          blane = $urandom_range(0, NCH - 1);
        end
        for (int i = 0; i < NCH; i++) ovr[i] = 1'b0;
        if (burst > 0) begin
          ovr[blane] = 1'b1; ovr_val[blane] = junk(); burst--;
        end
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
